fp_add_scheduler: RTL and testbench

//  Shares one FP32 adder core (alignment -> add -> normalize -> round) between NREQ requesters.

---
 rtl/fp_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/fp_add_scheduler.sv | 146 ++++++++++++++
 tb/tb_fp_add_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// ---------------------------------------------------------------------------
// fp_sched_pkg
//   Shared types for the FP32 adder scheduler.
//   FP_W          : width of one FP32 operand/result
//   fp32_t        : raw FP32 bit pattern (never interpreted by the scheduler)
//   sched_state_t : scheduler FSM states
// ---------------------------------------------------------------------------
package fp_sched_pkg;

    localparam int FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin grant. The search starts at ptr and walks
//   ptr, ptr+1, ... modulo N; the first requesting index wins. The pointer
//   itself is owned by the caller.
//   Ports:
//     req    in   N    request vector
//     ptr    in   IW   index searched first
//     gnt    out  N    one-hot grant (all-zero when nothing requests)
//     gntIdx out  IW   binary index of the grant
//     any    out  1    at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gntIdx,
    output logic          any
);

    // Walk the offsets from highest to lowest so the smallest offset from
    // ptr is the last one written and therefore wins.
    always_comb begin
        int idx;
        gnt    = '0;
        gntIdx = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gntIdx   = IW'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// ---------------------------------------------------------------------------
// fp_add_scheduler
//   Time-shares one FP32 adder core between NREQ requesters. A round-robin
//   arbiter accepts one operand pair, the operands are held on the core for
//   CORE_LAT+1 cycles, the core result is captured and returned together
//   with the requester ID over a valid/ready response port.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     req_valid/req_ready  per-requester handshake (req_ready one-hot)
//     req_a, req_b         packed FP32 operands, slice i = requester i
//     core_a, core_b       operands to the shared core
//     core_start           one-cycle pulse on the first EXEC cycle
//     core_result          sum returned by the core
//     rsp_valid/rsp_ready  response handshake
//     rsp_sum, rsp_id      captured sum and issuing requester
//     busy                 high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int CORE_LAT = 2,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output fp32_t                core_a,
    output fp32_t                core_b,
    output logic                 core_start,
    input  fp32_t                core_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output fp32_t                rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam int                CNT_W    = ($clog2(CORE_LAT + 1) < 1) ? 1 : $clog2(CORE_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CORE_LAT);
    localparam logic [IDW-1:0]    PTR_LAST = IDW'(NREQ - 1);

    sched_state_t   state;
    logic [IDW-1:0] rrPtr;
    logic [CNT_W-1:0] cnt;

    fp32_t          opA, opB, sumQ;
    logic [IDW-1:0] idQ;
    logic           startQ, rspValidQ, busyQ;

    logic [NREQ-1:0] gntOneHot;
    logic [IDW-1:0]  gntIdx;
    logic            gntAny;
    fp32_t           selA, selB;
    logic [IDW-1:0]  nextPtr;

    rr_arbiter #(.N(NREQ)) uArb (
        .req    (req_valid),
        .ptr    (rrPtr),
        .gnt    (gntOneHot),
        .gntIdx (gntIdx),
        .any    (gntAny)
    );

    // req_ready is only offered in IDLE; rst_n gating keeps it low while
    // reset is held even if requesters are already asserting valid.
    assign req_ready = (state == IDLE && rst_n) ? gntOneHot : '0;

    // Operand mux for the winning requester
    always_comb begin
        selA = '0;
        selB = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gntIdx == IDW'(i)) begin
                selA = req_a[i*FP_W +: FP_W];
                selB = req_b[i*FP_W +: FP_W];
            end
        end
    end

    assign nextPtr = (gntIdx == PTR_LAST) ? '0 : gntIdx + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rrPtr     <= '0;
            cnt       <= '0;
            opA       <= '0;
            opB       <= '0;
            sumQ      <= '0;
            idQ       <= '0;
            startQ    <= 1'b0;
            rspValidQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            startQ <= 1'b0;
            case (state)
                // Accept: in IDLE a grant is always a completed handshake
                IDLE: begin
                    if (gntAny) begin
                        opA    <= selA;
                        opB    <= selB;
                        idQ    <= gntIdx;
                        rrPtr  <= nextPtr;
                        cnt    <= '0;
                        startQ <= 1'b1;
                        busyQ  <= 1'b1;
                        state  <= EXEC;
                    end
                end
                // Execute: operands held on the core for CORE_LAT+1 cycles
                EXEC: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        sumQ      <= core_result;
                        rspValidQ <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Respond: sum/id frozen until the consumer accepts
                RESP: begin
                    if (rsp_ready) begin
                        rspValidQ <= 1'b0;
                        busyQ     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core_a     = opA;
    assign core_b     = opB;
    assign core_start = startQ;
    assign rsp_valid  = rspValidQ;
    assign rsp_sum    = sumQ;
    assign rsp_id     = idQ;
    assign busy       = busyQ;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fp_add_scheduler
//   Bench for fp_add_scheduler. One instance with CORE_LAT=2 fed by a
//   two-stage core model, one with CORE_LAT=0 fed by a combinational model.
// ---------------------------------------------------------------------------
module tb_fp_add_scheduler;

    localparam int NREQ = 4;
    localparam int CL   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // CORE_LAT=2 instance
    logic [NREQ-1:0]    reqValid, reqReady;
    logic [NREQ*32-1:0] reqA, reqB;
    logic [31:0]        coreA, coreB, coreResult, rspSum;
    logic               coreStart, rspValid, rspReady, busy;
    logic [1:0]         rspId;

    // CORE_LAT=0 instance
    logic [NREQ-1:0]    reqValidZ, reqReadyZ;
    logic [NREQ*32-1:0] reqAZ, reqBZ;
    logic [31:0]        coreAZ, coreBZ, coreResultZ, rspSumZ;
    logic               coreStartZ, rspValidZ, rspReadyZ, busyZ;
    logic [1:0]         rspIdZ;

    fp_add_scheduler #(.NREQ(NREQ), .CORE_LAT(CL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid), .req_ready(reqReady),
        .req_a(reqA), .req_b(reqB),
        .core_a(coreA), .core_b(coreB), .core_start(coreStart),
        .core_result(coreResult),
        .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_sum(rspSum), .rsp_id(rspId), .busy(busy)
    );

    fp_add_scheduler #(.NREQ(NREQ), .CORE_LAT(0)) dutZ (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValidZ), .req_ready(reqReadyZ),
        .req_a(reqAZ), .req_b(reqBZ),
        .core_a(coreAZ), .core_b(coreBZ), .core_start(coreStartZ),
        .core_result(coreResultZ),
        .rsp_valid(rspValidZ), .rsp_ready(rspReadyZ),
        .rsp_sum(rspSumZ), .rsp_id(rspIdZ), .busy(busyZ)
    );

    // Core model: exact FP32 sums for the operand pairs used here; anything
    // else yields a quiet NaN.
    function automatic logic [31:0] coreFn(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2=3
            {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2=4
            {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1=2
            {32'h40800000, 32'h40800000}: return 32'h41000000; // 4+4=8
            {32'h40400000, 32'hBF800000}: return 32'h40000000; // 3-1=2
            default:                      return 32'h7FC00000;
        endcase
    endfunction

    logic [31:0] pipe0 = '0;
    logic [31:0] pipe1 = '0;
    always @(posedge clk) begin
        pipe0 <= coreFn(coreA, coreB);
        pipe1 <= pipe0;
    end
    assign coreResult  = pipe1;
    assign coreResultZ = coreFn(coreAZ, coreBZ);

    logic [31:0] opA [NREQ];
    logic [31:0] opB [NREQ];

    typedef struct {
        logic [3:0]  valid;
        int          gnt;
        logic [31:0] sum;
        int          hold;
        bit          drop;
    } vec_t;
    vec_t vecs [8];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " req_ready"},  32'(reqReady),  32'd0);
        check({tag, " core_a"},     coreA,          32'd0);
        check({tag, " core_b"},     coreB,          32'd0);
        check({tag, " core_start"}, 32'(coreStart), 32'd0);
        check({tag, " rsp_valid"},  32'(rspValid),  32'd0);
        check({tag, " rsp_sum"},    rspSum,         32'd0);
        check({tag, " rsp_id"},     32'(rspId),     32'd0);
        check({tag, " busy"},       32'(busy),      32'd0);
    endtask

    // Entered at a falling edge with reqValid already set for this step.
    task automatic doTxn(input int g, input logic [31:0] expSum, input int hold,
                         input bit drop, input string tag);
        int w;
        rspReady = (hold == 0);
        #1;
        w = 0;
        while (reqReady == 4'b0 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, " grant"}, 32'(reqReady), 32'd1 << g);
        @(posedge clk);
        @(negedge clk);
        if (drop) reqValid[g] = 1'b0;
        check({tag, " start"}, 32'(coreStart), 32'd1);
        check({tag, " busy"},  32'(busy),      32'd1);
        for (int c = 0; c <= CL; c++) begin
            if (c > 0) begin
                @(negedge clk);
                check({tag, " start pulse"}, 32'(coreStart), 32'd0);
            end
            check({tag, " core_a"},     coreA,         opA[g]);
            check({tag, " core_b"},     coreB,         opB[g]);
            check({tag, " early rsp"},  32'(rspValid), 32'd0);
            check({tag, " ready exec"}, 32'(reqReady), 32'd0);
        end
        @(negedge clk);
        check({tag, " rsp_valid"}, 32'(rspValid), 32'd1);
        check({tag, " rsp_sum"},   rspSum,        expSum);
        check({tag, " rsp_id"},    32'(rspId),    32'(g));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " bp valid"}, 32'(rspValid), 32'd1);
            check({tag, " bp sum"},   rspSum,        expSum);
            check({tag, " bp id"},    32'(rspId),    32'(g));
            check({tag, " bp ready"}, 32'(reqReady), 32'd0);
            check({tag, " bp busy"},  32'(busy),     32'd1);
        end
        rspReady = 1'b1;
        @(negedge clk);
        check({tag, " rsp drop"}, 32'(rspValid), 32'd0);
        check({tag, " idle"},     32'(busy),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        opA[0] = 32'h3F800000; opB[0] = 32'h40000000;
        opA[1] = 32'h40000000; opB[1] = 32'h40000000;
        opA[2] = 32'h3F800000; opB[2] = 32'h3F800000;
        opA[3] = 32'h40800000; opB[3] = 32'h40800000;
        for (int i = 0; i < NREQ; i++) begin
            reqA[i*32 +: 32] = opA[i];
            reqB[i*32 +: 32] = opB[i];
        end
        reqAZ = {32'h0, 32'h0, 32'h0, 32'h40400000};
        reqBZ = {32'h0, 32'h0, 32'h0, 32'hBF800000};
        reqValidZ = '0;
        rspReadyZ = 1'b1;
        reqValid  = 4'hF;
        rspReady  = 1'b1;

        vecs[0] = '{4'b1111, 0, 32'h40400000, 0, 1'b0};
        vecs[1] = '{4'b1111, 1, 32'h40800000, 0, 1'b0};
        vecs[2] = '{4'b1111, 2, 32'h40000000, 0, 1'b0};
        vecs[3] = '{4'b1111, 3, 32'h41000000, 0, 1'b0};
        vecs[4] = '{4'b1111, 0, 32'h40400000, 5, 1'b0};
        vecs[5] = '{4'b0010, 1, 32'h40800000, 0, 1'b1};
        vecs[6] = '{4'b1010, 3, 32'h41000000, 0, 1'b1};
        vecs[7] = '{4'b1010, 1, 32'h40800000, 0, 1'b1};

        // Reset with all requesters already asserting valid
        @(negedge clk);
        @(negedge clk);
        #1;
        checkAllZero("reset");
        reqValid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 2
        reqValid = 4'b0100;
        doTxn(2, 32'h40000000, 0, 1'b1, "single");

        // Restart from reset so the pointer starts at 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            reqValid = vecs[i].valid;
            doTxn(vecs[i].gnt, vecs[i].sum, vecs[i].hold, vecs[i].drop, $sformatf("vec%0d", i));
        end

        // Reset while EXEC has cnt==1 (pointer is 2, requester 0 wins)
        reqValid = 4'b0001;
        #1;
        check("midrst grant", 32'(reqReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        reqValid = 4'b0011;
        @(negedge clk);
        check("midrst hold rsp", 32'(rspValid), 32'd0);
        check("midrst hold ready", 32'(reqReady), 32'd0);
        @(negedge clk);
        check("midrst hold rsp2", 32'(rspValid), 32'd0);
        rst_n = 1'b1;
        doTxn(0, 32'h40400000, 0, 1'b1, "postrst");
        reqValid = 4'b0000;

        // Combinational core: 3 + (-1)
        reqValidZ = 4'b0001;
        #1;
        check("lat0 grant", 32'(reqReadyZ), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValidZ = 4'b0000;
        check("lat0 start",  32'(coreStartZ), 32'd1);
        check("lat0 busy",   32'(busyZ),      32'd1);
        check("lat0 early",  32'(rspValidZ),  32'd0);
        check("lat0 core_a", coreAZ,          32'h40400000);
        check("lat0 core_b", coreBZ,          32'hBF800000);
        @(negedge clk);
        check("lat0 start off", 32'(coreStartZ), 32'd0);
        check("lat0 rsp_valid", 32'(rspValidZ),  32'd1);
        check("lat0 rsp_sum",   rspSumZ,         32'h40000000);
        check("lat0 rsp_id",    32'(rspIdZ),     32'd0);
        @(negedge clk);
        check("lat0 rsp drop",  32'(rspValidZ),  32'd0);
        check("lat0 idle",      32'(busyZ),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
